// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the unified L2 port between the I-cache and D-cache miss paths.
// One line-sized transaction is granted at a time. D wins ties, but a waiting I request
// is forced through after STARVE_LIMIT consecutive D grants. L2 strobes, responses and
// the response-cycle rdata are combinational from the granted requester and the L2.
module l2_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [CNT_WIDTH-1:0]  i_grant_count,
  output logic [CNT_WIDTH-1:0]  d_grant_count
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                state;
  logic [SC_W-1:0]       starve_cnt;
  logic [CNT_WIDTH-1:0]  i_cnt;
  logic [CNT_WIDTH-1:0]  d_cnt;
  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;
  logic                  d_req;
  logic                  d_allowed;

  assign d_req     = d_read | d_write;
  assign d_allowed = !i_read || (32'(starve_cnt) < STARVE_LIMIT);

  // Arbitration FSM, starvation tracking, response capture and grant counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      i_cnt      <= '0;
      d_cnt      <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && d_allowed) begin
            state      <= SERVE_D;
            starve_cnt <= i_read ? starve_cnt + SC_W'(1) : '0;
          end else if (i_read) begin
            state      <= SERVE_I;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        SERVE_I: begin
          if (!i_read) begin
            state <= RELEASE;
          end else if (l2_resp) begin
            state     <= RELEASE;
            i_rdata_q <= l2_rdata;
            if (i_cnt != '1) i_cnt <= i_cnt + CNT_WIDTH'(1);
          end
        end
        SERVE_D: begin
          if (!d_req) begin
            state <= RELEASE;
          end else if (l2_resp) begin
            state     <= RELEASE;
            d_rdata_q <= l2_rdata;
            if (d_cnt != '1) d_cnt <= d_cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Forward the granted requester to the L2 and route the response back to it only.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      SERVE_I: begin
        if (i_read) begin
          l2_read    = 1'b1;
          l2_address = i_address;
          i_resp     = l2_resp;
        end
      end
      SERVE_D: begin
        if (d_req) begin
          l2_write   = d_write;
          l2_read    = d_read & ~d_write;
          l2_address = d_address;
          l2_wdata   = d_wdata;
          d_resp     = l2_resp;
        end
      end
      default: ;
    endcase
    i_rdata = i_resp ? l2_rdata : i_rdata_q;
    d_rdata = d_resp ? l2_rdata : d_rdata_q;
  end

  assign i_grant_count = i_cnt;
  assign d_grant_count = d_cnt;

endmodule
